// File: rtl/branch_target_unit_pkg.sv
// Shared types and helpers for the branch target unit: op encoding and the alignment test.
package branch_target_unit_pkg;

    typedef enum logic [1:0] {
        BTU_JAL    = 2'b00,
        BTU_BRANCH = 2'b01,
        BTU_JALR   = 2'b10,
        BTU_RSVD   = 2'b11
    } btu_op_e;

    localparam int unsigned INSN_BYTES = 4;

    // A compressed-capable core only needs halfword alignment.
    function automatic logic is_misaligned(input logic [1:0] lsb, input logic align_c);
        return align_c ? lsb[0] : (|lsb);
    endfunction

endpackage

// File: rtl/branch_target_unit_if.sv
// Decode-side request and PC-select-side result bundle of the branch target unit.
interface branch_target_unit_if #(
    parameter int unsigned XLEN = 32
);
    import branch_target_unit_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    btu_op_e         op;
    logic            is_call;
    logic            is_ret;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] immed;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link_addr;
    logic            misaligned;
    logic            ras_valid;
    logic [XLEN-1:0] ras_pred;
    logic            ras_hit;

    modport master (
        output flush, in_valid, op, is_call, is_ret, pc, rs1, immed, out_ready,
        input  in_ready, out_valid, target, link_addr, misaligned, ras_valid, ras_pred, ras_hit
    );

    modport slave (
        input  flush, in_valid, op, is_call, is_ret, pc, rs1, immed, out_ready,
        output in_ready, out_valid, target, link_addr, misaligned, ras_valid, ras_pred, ras_hit
    );

endinterface

// File: rtl/branch_target_unit_ras.sv
// Circular return-address stack; a push onto a full stack silently replaces the oldest entry.
module return_addr_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            nonempty
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_n, wr_idx;
    logic [CW-1:0]   count_q, count_n;
    logic            do_pop, wr_en;

    assign do_pop = pop && (count_q != '0);

    // Coroutine (pop+push on a non-empty stack) just rewrites the current top in place.
    always_comb begin
        ptr_n   = ptr_q;
        count_n = count_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (push && do_pop) begin
            wr_en = 1'b1;
        end else if (push) begin
            ptr_n  = ptr_q + PW'(1);
            wr_idx = ptr_n;
            wr_en  = 1'b1;
            if (count_q != CW'(RAS_DEPTH)) begin
                count_n = count_q + CW'(1);
            end
        end else if (do_pop) begin
            ptr_n   = ptr_q - PW'(1);
            count_n = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_n;
            count_q <= count_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_idx] <= push_data;
        end
    end

    assign top      = mem[ptr_q];
    assign nonempty = (count_q != '0);

endmodule

// File: rtl/branch_target_unit.sv
// Registered JAL/branch/JALR target generator with link address, alignment flag and RAS prediction.
module branch_target_unit
    import branch_target_unit_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4,
    parameter bit          ALIGN_C   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    branch_target_unit_if.slave bus
);
    logic            ready_c, accept_c, ras_en_c;
    logic            push_c, pop_c, nonempty_c;
    logic [XLEN-1:0] top_c, target_c, link_c, pred_c;
    logic            mis_c, hit_c;

    logic            valid_q, mis_q, rv_q, hit_q;
    logic [XLEN-1:0] target_q, link_q, pred_q;

    assign ready_c  = !bus.flush && (!valid_q || bus.out_ready);
    assign accept_c = bus.in_valid && ready_c;
    assign ras_en_c = (bus.op != BTU_RSVD);
    assign push_c   = accept_c && ras_en_c && bus.is_call;
    assign pop_c    = accept_c && ras_en_c && bus.is_ret;

    return_addr_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .pop       (pop_c),
        .push_data (link_c),
        .top       (top_c),
        .nonempty  (nonempty_c)
    );

    // Target select and result flags for the request presented this cycle.
    always_comb begin
        link_c = bus.pc + XLEN'(INSN_BYTES);
        unique case (bus.op)
            BTU_JAL, BTU_BRANCH: target_c = bus.pc + bus.immed;
            BTU_JALR:            target_c = (bus.rs1 + bus.immed) & ~XLEN'(1);
            default:             target_c = link_c;
        endcase
        mis_c  = ras_en_c ? is_misaligned(target_c[1:0], ALIGN_C) : 1'b0;
        pred_c = nonempty_c ? top_c : '0;
        hit_c  = nonempty_c && bus.is_ret && (pred_c == target_c);
    end

    // Flush drops the pending result but leaves the data registers untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            target_q <= '0;
            link_q   <= '0;
            mis_q    <= 1'b0;
            rv_q     <= 1'b0;
            pred_q   <= '0;
            hit_q    <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept_c) begin
            valid_q  <= 1'b1;
            target_q <= target_c;
            link_q   <= link_c;
            mis_q    <= mis_c;
            rv_q     <= nonempty_c;
            pred_q   <= pred_c;
            hit_q    <= hit_c;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready   = ready_c;
    assign bus.out_valid  = valid_q;
    assign bus.target     = target_q;
    assign bus.link_addr  = link_q;
    assign bus.misaligned = mis_q;
    assign bus.ras_valid  = rv_q;
    assign bus.ras_pred   = pred_q;
    assign bus.ras_hit    = hit_q;

endmodule
